// File: rtl/alu_req_sched_pkg.sv
// rtl/alu_req_sched_pkg.sv - shared FSM encoding and ALU unit-select codes
package alu_req_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

endpackage

// File: rtl/alu_req_sched_if.sv
// rtl/alu_req_sched_if.sv - request, response and ALU-side signal bundle
interface alu_req_sched_if #(
    parameter int WIDTH = 16
);
    logic               req0_valid;
    logic               req0_ready;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic [3:0]         req0_fun;
    logic               req1_valid;
    logic               req1_ready;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic [3:0]         req1_fun;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_id;
    logic [2*WIDTH-1:0] resp_data;
    logic               resp_carry;
    logic               busy;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [3:0]         alu_fun;
    logic [2*WIDTH-1:0] alu_arith_out;
    logic               alu_carry_out;
    logic [WIDTH-1:0]   alu_logic_out;
    logic [1:0]         alu_cmp_out;
    logic [WIDTH-1:0]   alu_shift_out;

    modport master (
        output req0_valid, req0_a, req0_b, req0_fun,
        output req1_valid, req1_a, req1_b, req1_fun,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_data, resp_carry,
        output resp_ready,
        input  busy, alu_a, alu_b, alu_fun,
        output alu_arith_out, alu_carry_out, alu_logic_out, alu_cmp_out, alu_shift_out
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_fun,
        input  req1_valid, req1_a, req1_b, req1_fun,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_data, resp_carry,
        input  resp_ready,
        output busy, alu_a, alu_b, alu_fun,
        input  alu_arith_out, alu_carry_out, alu_logic_out, alu_cmp_out, alu_shift_out
    );
endinterface

// File: rtl/alu_req_sched_rr_arb2.sv
// rtl/alu_req_sched_rr_arb2.sv - two-way round-robin arbiter
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       gnt_valid
);
    // On contention the requester that did not win last time is chosen.
    assign grant     = (req == 2'b11) ? ~last_grant : req[1];
    assign gnt_valid = |req;
endmodule

// File: rtl/alu_req_sched.sv
// rtl/alu_req_sched.sv - two-requester scheduler in front of a registered 4-unit ALU
module alu_req_sched
    import alu_req_sched_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic          CLK,
    input  logic          RST,
    alu_req_sched_if.slave bus
);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t               state;
    logic                 last_grant;
    logic [CW-1:0]        lat_cnt;
    logic                 grant;
    logic                 gnt_valid;
    logic                 accept;
    logic [2*WIDTH-1:0]   cap_data;
    logic                 cap_carry;

    rr_arb2 u_arb (
        .req        ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_grant),
        .grant      (grant),
        .gnt_valid  (gnt_valid)
    );

    assign accept         = (state == S_IDLE) && gnt_valid;
    assign bus.req0_ready = accept && !grant;
    assign bus.req1_ready = accept && grant;
    assign bus.busy       = (state != S_IDLE);

    // Non-arith units are zero-extended and never report a carry.
    always_comb begin
        cap_data  = '0;
        cap_carry = 1'b0;
        case (bus.alu_fun[3:2])
            UNIT_ARITH: begin
                cap_data  = bus.alu_arith_out;
                cap_carry = bus.alu_carry_out;
            end
            UNIT_LOGIC: cap_data[WIDTH-1:0] = bus.alu_logic_out;
            UNIT_CMP:   cap_data[1:0]       = bus.alu_cmp_out;
            default:    cap_data[WIDTH-1:0] = bus.alu_shift_out;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state          <= S_IDLE;
            last_grant     <= 1'b1;
            lat_cnt        <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_fun    <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_id    <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_carry <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_valid) begin
                        bus.alu_a   <= grant ? bus.req1_a   : bus.req0_a;
                        bus.alu_b   <= grant ? bus.req1_b   : bus.req0_b;
                        bus.alu_fun <= grant ? bus.req1_fun : bus.req0_fun;
                        bus.resp_id <= grant;
                        last_grant  <= grant;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    lat_cnt <= CW'(ALU_LAT - 1);
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        bus.resp_data  <= cap_data;
                        bus.resp_carry <= cap_carry;
                        bus.resp_valid <= 1'b1;
                        state          <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_sched.sv
// tb/tb_alu_req_sched.sv - directed and randomized self-checking bench for alu_req_sched
module tb_alu_req_sched;
    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    alu_req_sched_if #(.WIDTH(16)) bus ();

    alu_req_sched #(.WIDTH(16), .ALU_LAT(1)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    function automatic logic [31:0] f_arith(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return {16'h0, a} + {16'h0, b};
            2'b01:   return {16'h0, a} - {16'h0, b};
            2'b10:   return {16'h0, a} * {16'h0, b};
            default: return (b == 16'h0) ? 32'h0 : {16'h0, a / b};
        endcase
    endfunction

    function automatic logic [15:0] f_logic(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    function automatic logic [1:0] f_cmp(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return 2'd0;
            2'b01:   return (a == b) ? 2'd1 : 2'd0;
            2'b10:   return (a > b)  ? 2'd2 : 2'd0;
            default: return (a < b)  ? 2'd3 : 2'd0;
        endcase
    endfunction

    function automatic logic [15:0] f_shift(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return a >> 1;
            2'b01:   return a << 1;
            2'b10:   return b >> 1;
            default: return b << 1;
        endcase
    endfunction

    function automatic logic [32:0] ref_op(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] ar;
        ar = f_arith(fun[1:0], a, b);
        case (fun[3:2])
            2'b00:   return {ar[16], ar};
            2'b01:   return {17'h0, f_logic(fun[1:0], a, b)};
            2'b10:   return {31'h0, f_cmp(fun[1:0], a, b)};
            default: return {17'h0, f_shift(fun[1:0], a, b)};
        endcase
    endfunction

    // Registered ALU stand-in, one clock of latency.
    logic [31:0] m_ar;
    always @(posedge CLK) begin
        m_ar = f_arith(bus.alu_fun[1:0], bus.alu_a, bus.alu_b);
        bus.alu_arith_out <= m_ar;
        bus.alu_carry_out <= m_ar[16];
        bus.alu_logic_out <= f_logic(bus.alu_fun[1:0], bus.alu_a, bus.alu_b);
        bus.alu_cmp_out   <= f_cmp(bus.alu_fun[1:0], bus.alu_a, bus.alu_b);
        bus.alu_shift_out <= f_shift(bus.alu_fun[1:0], bus.alu_a, bus.alu_b);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_any_ready(input string tag);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) break;
            @(posedge CLK);
        end
        check(tag, bus.req0_ready | bus.req1_ready, 1'b1);
    endtask

    task automatic wait_resp(input string tag);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.resp_valid) break;
            @(posedge CLK);
        end
        check(tag, bus.resp_valid, 1'b1);
    endtask

    task automatic run_op(input string tag, input logic id, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] fun, input logic [31:0] exp_d, input logic exp_c);
        if (id) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_fun = fun; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_fun = fun; bus.req0_valid = 1'b1;
        end
        bus.resp_ready = 1'b1;
        wait_any_ready({tag, "_rdy"});
        step;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_resp({tag, "_rv"});
        check({tag, "_data"}, bus.resp_data, exp_d);
        check({tag, "_carry"}, bus.resp_carry, exp_c);
        check({tag, "_id"}, bus.resp_id, id);
        step;
    endtask

    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic        acc0, acc1, rsp, rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_carry;
    logic [32:0] exp_e;
    int          issued, rcvd, ncyc;

    initial begin
        RST = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_fun = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_fun = '0;
        bus.resp_ready = 1'b0;
        step;
        step;
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_alu_regs", {bus.alu_a, bus.alu_b, bus.alu_fun}, 36'h0);
        check("rst_resp_regs", {bus.resp_id, bus.resp_carry, bus.resp_data}, 34'h0);
        RST = 1'b1;

        // Add with carry, latency n+3.
        bus.req0_a = 16'hFFFF; bus.req0_b = 16'h0001; bus.req0_fun = 4'b0000;
        bus.req0_valid = 1'b1; bus.resp_ready = 1'b1;
        #1;
        check("add_ready0", bus.req0_ready, 1'b1);
        check("add_ready1", bus.req1_ready, 1'b0);
        step;
        bus.req0_valid = 1'b0;
        check("add_n1_busy", bus.busy, 1'b1);
        check("add_n1_rv", bus.resp_valid, 1'b0);
        step;
        check("add_n2_rv", bus.resp_valid, 1'b0);
        step;
        check("add_n3_rv", bus.resp_valid, 1'b1);
        check("add_data", bus.resp_data, 32'h0001_0000);
        check("add_carry", bus.resp_carry, 1'b1);
        check("add_id", bus.resp_id, 1'b0);
        step;
        check("add_done_rv", bus.resp_valid, 1'b0);
        check("add_done_busy", bus.busy, 1'b0);

        // Reset while an op is in WAIT drops it and restores req0 priority.
        bus.req0_a = 16'h0003; bus.req0_b = 16'h0005; bus.req0_fun = 4'b0010;
        bus.req0_valid = 1'b1;
        #1;
        check("mid_rst_accept", bus.req0_ready, 1'b1);
        step;
        bus.req0_valid = 1'b0;
        step;
        check("mid_rst_busy_before", bus.busy, 1'b1);
        RST = 1'b0;
        step;
        step;
        RST = 1'b1;
        check("mid_rst_rv", bus.resp_valid, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_alu_fun", bus.alu_fun, 4'h0);

        // Contention: grants alternate starting with req0.
        bus.req0_a = 16'h0003; bus.req0_b = 16'h0004; bus.req0_fun = 4'b0000;
        bus.req1_a = 16'h00F0; bus.req1_b = 16'h0F00; bus.req1_fun = 4'b0101;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_any_ready("rr_wait");
            check("rr_ready0", bus.req0_ready, (k % 2) == 0);
            check("rr_ready1", bus.req1_ready, (k % 2) == 1);
            step;
            wait_resp("rr_rv");
            check("rr_id", bus.resp_id, (k % 2) == 1);
            check("rr_data", bus.resp_data, ((k % 2) == 1) ? 32'h0000_0FF0 : 32'h0000_0007);
            step;
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

        // Backpressure on a compare result; req0 waits meanwhile.
        bus.req1_a = 16'd5; bus.req1_b = 16'd5; bus.req1_fun = 4'b1001; bus.req1_valid = 1'b1;
        bus.resp_ready = 1'b0;
        wait_any_ready("bp_wait");
        check("bp_ready1", bus.req1_ready, 1'b1);
        step;
        bus.req1_valid = 1'b0;
        bus.req0_a = 16'd2; bus.req0_b = 16'd3; bus.req0_fun = 4'b0000; bus.req0_valid = 1'b1;
        wait_resp("bp_rv");
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_rv", bus.resp_valid, 1'b1);
            check("bp_hold_data", {bus.resp_id, bus.resp_carry, bus.resp_data}, {2'b10, 32'h1});
            check("bp_hold_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
            step;
            #1;
        end
        bus.resp_ready = 1'b1;
        step;
        check("bp_rel_rv", bus.resp_valid, 1'b0);
        check("bp_rel_busy", bus.busy, 1'b0);
        #1;
        check("bp_rel_ready0", bus.req0_ready, 1'b1);
        step;
        bus.req0_valid = 1'b0;
        wait_resp("bp_next_rv");
        check("bp_next_data", bus.resp_data, 32'h5);
        check("bp_next_id", bus.resp_id, 1'b0);
        step;

        // One op per unit.
        run_op("nand", 1'b0, 16'h00FF, 16'h0F0F, 4'b0110, 32'h0000_FFF0, 1'b0);
        run_op("shl",  1'b1, 16'h8001, 16'h0000, 4'b1101, 32'h0000_0002, 1'b0);
        run_op("mul",  1'b0, 16'h0300, 16'h0100, 4'b0010, 32'h0003_0000, 1'b1);
        run_op("cmpgt", 1'b1, 16'h0009, 16'h0004, 4'b1010, 32'h0000_0002, 1'b0);
        run_op("sub",  1'b0, 16'h0001, 16'h0002, 4'b0001, 32'hFFFF_FFFF, 1'b1);

        // Random traffic with per-requester in-order scoreboard.
        issued = 0; rcvd = 0; ncyc = 0;
        while (rcvd < 1000 && ncyc < 40000) begin
            if (!bus.req0_valid && issued < 1000 && $urandom_range(0, 1) == 1) begin
                bus.req0_a = 16'($urandom); bus.req0_b = 16'($urandom);
                bus.req0_fun = 4'($urandom_range(0, 15)); bus.req0_valid = 1'b1; issued++;
            end
            if (!bus.req1_valid && issued < 1000 && $urandom_range(0, 1) == 1) begin
                bus.req1_a = 16'($urandom); bus.req1_b = 16'($urandom);
                bus.req1_fun = 4'($urandom_range(0, 15)); bus.req1_valid = 1'b1; issued++;
            end
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            check("rnd_ready_onehot", bus.req0_ready & bus.req1_ready, 1'b0);
            acc0 = bus.req0_valid & bus.req0_ready;
            acc1 = bus.req1_valid & bus.req1_ready;
            rsp = bus.resp_valid & bus.resp_ready;
            rsp_id = bus.resp_id; rsp_data = bus.resp_data; rsp_carry = bus.resp_carry;
            @(posedge CLK);
            #1;
            ncyc++;
            if (acc0) begin
                q0.push_back(ref_op(bus.req0_fun, bus.req0_a, bus.req0_b));
                bus.req0_valid = 1'b0;
            end
            if (acc1) begin
                q1.push_back(ref_op(bus.req1_fun, bus.req1_a, bus.req1_b));
                bus.req1_valid = 1'b0;
            end
            if (rsp) begin
                rcvd++;
                check("rnd_sb_nonempty", (rsp_id ? q1.size() : q0.size()) != 0, 1'b1);
                if ((rsp_id ? q1.size() : q0.size()) != 0) begin
                    exp_e = rsp_id ? q1.pop_front() : q0.pop_front();
                    check("rnd_result", {rsp_carry, rsp_data}, exp_e);
                end
            end
        end
        check("rnd_all_responses", rcvd, 1000);
        check("rnd_q_empty", q0.size() + q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
